// File: rtl/golden_nonce_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : golden_nonce_uart_tx
// Purpose  : Queues golden nonces from the hashcore result path in a small
//            FIFO and sends each one to the host as four 8N1 UART bytes,
//            least-significant byte first.
// Ports    : hash_clk           - hashing clock, all state on rising edge
//            reset_n            - asynchronous active-low reset
//            golden_nonce_in    - nonce, valid while golden_nonce_match is high
//            golden_nonce_match - push strobe (one word per high cycle)
//            txd                - registered UART serial output, idle high
//            busy               - frame in progress or words still queued
//            overflow           - sticky, a match was dropped on a full FIFO
//            fifo_count         - words queued, excluding the word on the wire
// Revision : 1.0 - initial release
// ============================================================================
module golden_nonce_uart_tx #(
    parameter int BAUD_DIV = 217,   // hash_clk cycles per UART bit, 2..65535
    parameter int FIFO_AW  = 2      // FIFO depth = 2**FIFO_AW words
) (
    input  logic             hash_clk,
    input  logic             reset_n,
    input  logic [31:0]      golden_nonce_in,
    input  logic             golden_nonce_match,
    output logic             txd,
    output logic             busy,
    output logic             overflow,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int                 DEPTH       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   c_full      = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   c_cnt_one   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] c_ptr_one   = FIFO_AW'(1);
    localparam logic [15:0]        c_baud_last = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Registered state
    state_t             r_state;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit_idx;
    logic [1:0]         r_byte_idx;
    logic [31:0]        r_shift;
    logic               r_txd;
    logic               r_overflow;
    logic [FIFO_AW:0]   r_count;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [31:0]        r_mem [DEPTH];

    // Next-state / control
    state_t             w_state_n;
    logic [15:0]        w_baud_n;
    logic [2:0]         w_bit_idx_n;
    logic [1:0]         w_byte_idx_n;
    logic [31:0]        w_shift_n;
    logic               w_txd_n;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_baud_wrap;
    logic [7:0]         w_byte;

    assign w_baud_wrap = (r_baud == c_baud_last);
    assign w_byte      = r_shift[7:0];

    // A pop frees a slot in the same edge, so a match that coincides with
    // an IDLE pop is accepted even when the FIFO is full.
    assign w_push = golden_nonce_match && ((r_count != c_full) || w_pop);
    assign w_drop = golden_nonce_match && !w_push;

    // ------------------------------------------------------------------
    // Next-state logic. txd is registered, so the value computed here is
    // the level the line takes during the cycle the FSM moves into; that
    // is what makes the start bit appear right after the pop edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n    = r_state;
        w_baud_n     = r_baud;
        w_bit_idx_n  = r_bit_idx;
        w_byte_idx_n = r_byte_idx;
        w_shift_n    = r_shift;
        w_txd_n      = 1'b1;
        w_pop        = 1'b0;

        if (r_state != ST_IDLE) begin
            w_baud_n = w_baud_wrap ? 16'd0 : r_baud + 16'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_n    = r_mem[r_rd_ptr];
                    w_byte_idx_n = 2'd0;
                    w_baud_n     = 16'd0;
                    w_state_n    = ST_START;
                    w_txd_n      = 1'b0;
                end
            end
            ST_START: begin
                w_txd_n = 1'b0;
                if (w_baud_wrap) begin
                    w_bit_idx_n = 3'd0;
                    w_state_n   = ST_DATA;
                    w_txd_n     = w_byte[0];
                end
            end
            ST_DATA: begin
                w_txd_n = w_byte[r_bit_idx];
                if (w_baud_wrap) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = ST_STOP;
                        w_txd_n   = 1'b1;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                        w_txd_n     = w_byte[r_bit_idx + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                w_txd_n = 1'b1;
                if (w_baud_wrap) begin
                    if (r_byte_idx != 2'd3) begin
                        // Next byte follows immediately, no inter-byte gap.
                        w_byte_idx_n = r_byte_idx + 2'd1;
                        w_shift_n    = {8'd0, r_shift[31:8]};
                        w_state_n    = ST_START;
                        w_txd_n      = 1'b0;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_baud     <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 32'd0;
            r_txd      <= 1'b1;
            r_overflow <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_state    <= w_state_n;
            r_baud     <= w_baud_n;
            r_bit_idx  <= w_bit_idx_n;
            r_byte_idx <= w_byte_idx_n;
            r_shift    <= w_shift_n;
            r_txd      <= w_txd_n;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define which words
    // are valid, and a reset empties the FIFO by clearing them.
    always_ff @(posedge hash_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= golden_nonce_in;
        end
    end

    assign txd        = r_txd;
    assign busy       = (r_state != ST_IDLE) || (r_count != '0);
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_golden_nonce_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_golden_nonce_uart_tx
// Purpose  : Self-checking bench for golden_nonce_uart_tx. A fast instance
//            (BAUD_DIV=4) covers function, ordering, FIFO full/overflow and
//            reset; a second instance at BAUD_DIV=217 covers real bit timing.
//            A UART receiver decodes txd; expected words and byte start times
//            come from a queue model and plain frame arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_golden_nonce_uart_tx;

    localparam int B     = 4;
    localparam int BS    = 217;
    localparam int DEPTH = 4;

    logic        hash_clk;
    logic        reset_n;
    logic [31:0] nonce_f, nonce_s;
    logic        match_f, match_s;
    logic        txd_f, txd_s, busy_f, busy_s, ovf_f, ovf_s;
    logic [2:0]  cnt_f, cnt_s;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rxb_f[$];
    logic [7:0] rxb_s[$];
    int         rxt_f[$];
    int         rxt_s[$];

    golden_nonce_uart_tx #(.BAUD_DIV(B), .FIFO_AW(2)) dut (
        .hash_clk(hash_clk), .reset_n(reset_n),
        .golden_nonce_in(nonce_f), .golden_nonce_match(match_f),
        .txd(txd_f), .busy(busy_f), .overflow(ovf_f), .fifo_count(cnt_f)
    );

    golden_nonce_uart_tx #(.BAUD_DIV(BS), .FIFO_AW(2)) dut_slow (
        .hash_clk(hash_clk), .reset_n(reset_n),
        .golden_nonce_in(nonce_s), .golden_nonce_match(match_s),
        .txd(txd_s), .busy(busy_s), .overflow(ovf_s), .fifo_count(cnt_s)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;
    always @(posedge hash_clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    // UART receiver: every bit must hold one level for exactly bw cycles
    // and the stop bit must be high. Frames cut short by reset are dropped.
    task automatic rx_run(input bit slow);
        int         bw;
        int         t0;
        logic       cur;
        logic       v;
        logic [7:0] b;
        bit         bad;
        bit         abort;
        bw = slow ? BS : B;
        forever begin
            @(posedge hash_clk);
            #2;
            cur = slow ? txd_s : txd_f;
            if (reset_n === 1'b1 && cur === 1'b0) begin
                t0 = cyc; bad = 0; abort = 0; b = 8'h00; v = 1'b0;
                for (int k = 0; k < 10 && !abort; k++) begin
                    for (int s = 0; s < bw && !abort; s++) begin
                        if (k != 0 || s != 0) begin
                            @(posedge hash_clk);
                            #2;
                            cur = slow ? txd_s : txd_f;
                        end
                        if (reset_n !== 1'b1) abort = 1;
                        else if (s == 0) v = cur;
                        else if (cur !== v) bad = 1;
                    end
                    if (k >= 1 && k <= 8) b[k-1] = v;
                    if (k == 9 && v !== 1'b1) bad = 1;
                end
                if (!abort) begin
                    vectors++;
                    if (bad) begin
                        miscompares++;
                        $display("FAIL rx_frame: slow=%0d byte started at cycle %0d glitched or lacks stop bit (got byte %h, required clean 8N1)",
                                 slow, t0, b);
                    end
                    if (slow) begin rxb_s.push_back(b); rxt_s.push_back(t0); end
                    else      begin rxb_f.push_back(b); rxt_f.push_back(t0); end
                end
            end
        end
    endtask

    initial rx_run(1'b0);
    initial rx_run(1'b1);

    task automatic apply_reset();
        match_f = 1'b0; match_s = 1'b0;
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        rxb_f.delete(); rxt_f.delete(); rxb_s.delete(); rxt_s.delete();
    endtask

    task automatic wait_idle_f(input int limit, output int fall, output int peak);
        fall = -1;
        peak = 0;
        for (int i = 0; i < limit; i++) begin
            if (int'(cnt_f) > peak) peak = int'(cnt_f);
            if (busy_f === 1'b0) begin
                fall = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        nonce_f = 32'h0; nonce_s = 32'h0;
        match_f = 1'b0; match_s = 1'b0;
        reset_n = 1'b0;
        tick(); tick();
        vectors++; if (txd_f !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b required 1", txd_f); end
        vectors++; if (busy_f !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b required 0", busy_f); end
        vectors++; if (ovf_f !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b required 0", ovf_f); end
        vectors++; if (cnt_f !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d required 0", cnt_f); end
        vectors++; if (txd_s !== 1'b1 || busy_s !== 1'b0 || cnt_s !== 3'd0) begin
            miscompares++; $display("FAIL reset_slow: got txd=%b busy=%b count=%0d required 1/0/0", txd_s, busy_s, cnt_s);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single(input logic [31:0] w);
        int n, fall, peak;
        logic [31:0] got;
        apply_reset();
        nonce_f = w; match_f = 1'b1; n = cyc;
        tick();
        match_f = 1'b0; nonce_f = $urandom;
        vectors++; if (cnt_f !== 3'd1 || txd_f !== 1'b1) begin
            miscompares++; $display("FAIL single_push: got count=%0d txd=%b required 1/1", cnt_f, txd_f);
        end
        tick();
        vectors++; if (txd_f !== 1'b0 || cnt_f !== 3'd0 || busy_f !== 1'b1) begin
            miscompares++; $display("FAIL single_start: got txd=%b count=%0d busy=%b required 0/0/1", txd_f, cnt_f, busy_f);
        end
        wait_idle_f(1000, fall, peak);
        vectors++; if (fall != n + 2 + 40 * B) begin
            miscompares++; $display("FAIL single_busy_fall: got cycle %0d required %0d", fall, n + 2 + 40 * B);
        end
        tick(); tick();
        got = 32'hx;
        if (rxb_f.size() == 4) got = {rxb_f[3], rxb_f[2], rxb_f[1], rxb_f[0]};
        vectors++; if (got !== w) begin
            miscompares++; $display("FAIL single_word: got %h (%0d bytes) required %h", got, rxb_f.size(), w);
        end
        vectors++; if (rxt_f.size() < 1 || rxt_f[0] != n + 2) begin
            miscompares++; $display("FAIL single_latency: got start cycle %0d required %0d", (rxt_f.size() > 0) ? rxt_f[0] : -1, n + 2);
        end
        vectors++; if (ovf_f !== 1'b0) begin miscompares++; $display("FAIL single_overflow: got %b required 0", ovf_f); end
    endtask

    task automatic test_back_to_back(input logic [31:0] w0, input logic [31:0] w1);
        int n, fall, peak, k;
        logic [31:0] exp[$];
        apply_reset();
        exp = {w0, w1};
        nonce_f = w0; match_f = 1'b1; n = cyc;
        tick();
        nonce_f = w1;
        tick();
        match_f = 1'b0;
        wait_idle_f(2000, fall, peak);
        tick(); tick();
        vectors++; if (peak != 1) begin miscompares++; $display("FAIL b2b_peak_count: got %0d required 1", peak); end
        vectors++; if (fall != n + 2 + 80 * B + 1) begin
            miscompares++; $display("FAIL b2b_busy_fall: got cycle %0d required %0d", fall, n + 2 + 80 * B + 1);
        end
        vectors++; if (rxb_f.size() != 8) begin miscompares++; $display("FAIL b2b_byte_count: got %0d required 8", rxb_f.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            for (int j = 0; j < 4; j++) begin
                k = i * 4 + j;
                vectors++;
                if (k >= rxb_f.size() || rxb_f[k] !== exp[i][8*j +: 8] || rxt_f[k] != n + 2 + i * (40 * B + 1) + j * 10 * B) begin
                    miscompares++;
                    $display("FAIL b2b_byte%0d: got %h at cycle %0d required %h at cycle %0d", k,
                             (k < rxb_f.size()) ? rxb_f[k] : 8'hxx, (k < rxt_f.size()) ? rxt_f[k] : -1,
                             exp[i][8*j +: 8], n + 2 + i * (40 * B + 1) + j * 10 * B);
                end
            end
        end
    endtask

    // One word goes on the wire, then `extra` matches arrive while it shifts.
    task automatic test_overflow(input int extra);
        int n, fall, peak, k, model_q;
        bit model_drop;
        logic [31:0] exp[$];
        logic [31:0] w;
        apply_reset();
        w = $urandom; exp = {w};
        model_q = 0; model_drop = 0;
        nonce_f = w; match_f = 1'b1; n = cyc;
        tick();
        match_f = 1'b0;
        tick();
        for (int e = 0; e < extra; e++) begin
            w = $urandom;
            nonce_f = w; match_f = 1'b1;
            if (model_q < DEPTH) begin exp.push_back(w); model_q++; end
            else model_drop = 1;
            tick();
        end
        match_f = 1'b0;
        vectors++; if (int'(cnt_f) != model_q) begin miscompares++; $display("FAIL ovf_count: got %0d required %0d", cnt_f, model_q); end
        vectors++; if (ovf_f !== model_drop) begin miscompares++; $display("FAIL ovf_flag: got %b required %b", ovf_f, model_drop); end
        wait_idle_f(3000, fall, peak);
        tick(); tick();
        vectors++; if (fall != n + 2 + exp.size() * 40 * B + exp.size() - 1) begin
            miscompares++; $display("FAIL ovf_busy_fall: got cycle %0d required %0d", fall, n + 2 + exp.size() * 40 * B + exp.size() - 1);
        end
        vectors++; if (ovf_f !== model_drop) begin miscompares++; $display("FAIL ovf_sticky: got %b required %b", ovf_f, model_drop); end
        vectors++; if (rxb_f.size() != 4 * exp.size()) begin
            miscompares++; $display("FAIL ovf_byte_count: got %0d required %0d", rxb_f.size(), 4 * exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            for (int j = 0; j < 4; j++) begin
                k = i * 4 + j;
                vectors++;
                if (k >= rxb_f.size() || rxb_f[k] !== exp[i][8*j +: 8] || rxt_f[k] != n + 2 + i * (40 * B + 1) + j * 10 * B) begin
                    miscompares++;
                    $display("FAIL ovf_byte%0d: got %h at cycle %0d required %h at cycle %0d", k,
                             (k < rxb_f.size()) ? rxb_f[k] : 8'hxx, (k < rxt_f.size()) ? rxt_f[k] : -1,
                             exp[i][8*j +: 8], n + 2 + i * (40 * B + 1) + j * 10 * B);
                end
            end
        end
    endtask

    // FIFO full when the first frame ends; a match lands in the IDLE pop cycle.
    task automatic test_full_pop();
        int n, fall, peak, k;
        logic [31:0] exp[$];
        logic [31:0] w;
        apply_reset();
        w = $urandom; exp = {w};
        nonce_f = w; match_f = 1'b1; n = cyc;
        tick();
        match_f = 1'b0;
        tick();
        for (int e = 0; e < DEPTH; e++) begin
            w = $urandom; exp.push_back(w);
            nonce_f = w; match_f = 1'b1;
            tick();
        end
        match_f = 1'b0;
        for (int i = 0; i < 400 && cyc < n + 1 + 40 * B; i++) tick();
        vectors++; if (cnt_f !== 3'd4) begin miscompares++; $display("FAIL fullpop_before: got count %0d required 4", cnt_f); end
        tick();
        w = $urandom; exp.push_back(w);
        nonce_f = w; match_f = 1'b1;
        tick();
        match_f = 1'b0;
        vectors++; if (cnt_f !== 3'd4 || ovf_f !== 1'b0) begin
            miscompares++; $display("FAIL fullpop_after: got count=%0d overflow=%b required 4/0", cnt_f, ovf_f);
        end
        wait_idle_f(3000, fall, peak);
        tick(); tick();
        vectors++; if (fall != n + 2 + 6 * 40 * B + 5) begin
            miscompares++; $display("FAIL fullpop_busy_fall: got cycle %0d required %0d", fall, n + 2 + 6 * 40 * B + 5);
        end
        for (int i = 0; i < exp.size(); i++) begin
            for (int j = 0; j < 4; j++) begin
                k = i * 4 + j;
                vectors++;
                if (k >= rxb_f.size() || rxb_f[k] !== exp[i][8*j +: 8] || rxt_f[k] != n + 2 + i * (40 * B + 1) + j * 10 * B) begin
                    miscompares++;
                    $display("FAIL fullpop_byte%0d: got %h at cycle %0d required %h at cycle %0d", k,
                             (k < rxb_f.size()) ? rxb_f[k] : 8'hxx, (k < rxt_f.size()) ? rxt_f[k] : -1,
                             exp[i][8*j +: 8], n + 2 + i * (40 * B + 1) + j * 10 * B);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n, fall, peak;
        logic [31:0] w;
        logic [31:0] got;
        apply_reset();
        w = $urandom;
        w[23:16] = 8'h00;  // byte 2 all zeros so the aborted bit is low
        nonce_f = w; match_f = 1'b1; n = cyc;
        tick();
        match_f = 1'b0;
        tick();
        for (int e = 0; e < DEPTH + 1; e++) begin
            nonce_f = $urandom; match_f = 1'b1;
            tick();
        end
        match_f = 1'b0;
        for (int i = 0; i < 400 && cyc < n + 2 + 24 * B; i++) tick();
        vectors++; if (txd_f !== 1'b0 || ovf_f !== 1'b1) begin
            miscompares++; $display("FAIL midrst_pre: got txd=%b overflow=%b required 0/1", txd_f, ovf_f);
        end
        reset_n = 1'b0;
        #1;
        vectors++; if (txd_f !== 1'b1) begin miscompares++; $display("FAIL midrst_txd: got %b required 1", txd_f); end
        vectors++; if (cnt_f !== 3'd0 || ovf_f !== 1'b0 || busy_f !== 1'b0) begin
            miscompares++; $display("FAIL midrst_state: got count=%0d overflow=%b busy=%b required 0/0/0", cnt_f, ovf_f, busy_f);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        rxb_f.delete(); rxt_f.delete();
        w = $urandom;
        nonce_f = w; match_f = 1'b1; n = cyc;
        tick();
        match_f = 1'b0;
        wait_idle_f(1000, fall, peak);
        tick(); tick();
        got = 32'hx;
        if (rxb_f.size() == 4) got = {rxb_f[3], rxb_f[2], rxb_f[1], rxb_f[0]};
        vectors++; if (got !== w || rxt_f.size() < 1 || rxt_f[0] != n + 2) begin
            miscompares++; $display("FAIL midrst_recover: got %h (%0d bytes) required %h starting cycle %0d", got, rxb_f.size(), w, n + 2);
        end
    endtask

    task automatic test_slow_baud();
        int n, fall;
        logic [31:0] w;
        logic [31:0] got;
        apply_reset();
        w = $urandom;
        nonce_s = w; match_s = 1'b1; n = cyc;
        tick();
        match_s = 1'b0;
        fall = -1;
        for (int i = 0; i < 10000; i++) begin
            if (busy_s === 1'b0 && cyc > n + 2) begin fall = cyc; break; end
            tick();
        end
        tick(); tick();
        vectors++; if (fall != n + 2 + 40 * BS) begin
            miscompares++; $display("FAIL slow_frame_length: got busy fall cycle %0d required %0d", fall, n + 2 + 40 * BS);
        end
        got = 32'hx;
        if (rxb_s.size() == 4) got = {rxb_s[3], rxb_s[2], rxb_s[1], rxb_s[0]};
        vectors++; if (got !== w) begin miscompares++; $display("FAIL slow_word: got %h required %h", got, w); end
        vectors++; if (rxt_s.size() != 4 || rxt_s[0] != n + 2 || rxt_s[3] != n + 2 + 30 * BS) begin
            miscompares++; $display("FAIL slow_byte_timing: got %0d starts, first %0d required 4 starts from %0d",
                                    rxt_s.size(), (rxt_s.size() > 0) ? rxt_s[0] : -1, n + 2);
        end
    endtask

    initial begin
        test_reset();
        test_single(32'h0000318f);
        test_single($urandom);
        test_single($urandom);
        test_back_to_back(32'h11223344, 32'hAABBCCDD);
        test_back_to_back($urandom, $urandom);
        test_overflow(5);
        test_overflow(int'($urandom_range(2, 4)));
        test_full_pop();
        test_reset_mid_frame();
        test_slow_baud();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/golden_nonce_uart_tx.md
Name: golden_nonce_uart_tx

Overview:
- Downstream of the hashcore result path.
- Captures each golden nonce flagged by golden_nonce_match into a small FIFO.
- Serializes each captured nonce as four 8N1 UART bytes, least-significant byte first, on txd.
- Gives serial-comms builds (no JTAG virtual wire) a result channel to the host, and tolerates back-to-back matches from multicore instances.

Parameters:
- BAUD_DIV, 217, hash_clk cycles per UART bit (25 MHz / 115200); legal range 2..65535.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW words of 32 bits.

Ports:
- hash_clk  input  1  hashing clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- golden_nonce_in  input  32  nonce value, valid in the cycle golden_nonce_match is high.
- golden_nonce_match  input  1  single-cycle strobe: push golden_nonce_in.
- txd  output  1  UART serial data, idle high.
- busy  output  1  high while a frame is being shifted or the FIFO is non-empty.
- overflow  output  1  sticky: a match was dropped because the FIFO was full.
- fifo_count  output  FIFO_AW+1  number of words queued, not counting the word being transmitted.

Behaviour:
- Reset, asynchronous on reset_n low:
  - txd=1, busy=0, overflow=0, fifo_count=0.
  - FSM goes to IDLE; bit counter and baud counter are cleared.
  - A reset mid-frame aborts the frame immediately. txd is forced high without completing the byte. Queued words are discarded.
- Push:
  - golden_nonce_match high in cycle N writes golden_nonce_in at the edge ending cycle N.
  - fifo_count reflects the push from cycle N+1.
  - Match held high for k cycles pushes k words. The source strobes for one cycle only.
- Full:
  - A match while fifo_count==2**FIFO_AW with no pop in the same cycle is dropped and sets overflow=1.
  - overflow stays set until reset.
  - Match in the same cycle as a pop while full is accepted; count is unchanged.
- Pop: occurs only in IDLE when fifo_count>0. The word is loaded into a 32-bit shift register and fifo_count decrements at that edge.
- FSM states:
  - IDLE: txd=1.
    - If fifo_count>0: pop, byte_idx=0, go to START.
  - START: txd=0 for BAUD_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: txd=current byte bit[bit_idx], LSB first, for BAUD_DIV cycles per bit.
    - After bit 7, go to STOP.
  - STOP: txd=1 for BAUD_DIV cycles.
    - If byte_idx<3: byte_idx++, shift the word right by 8, go to START (no gap between bytes).
    - Else go to IDLE.
- Byte order on the wire: nonce[7:0], [15:8], [23:16], [31:24].
- Latency:
  - Match at cycle N into an empty FIFO with FSM idle: pop in cycle N+1, txd falls at the start of cycle N+2.
  - One word occupies exactly 40*BAUD_DIV cycles.
  - Back-to-back queued words are separated by exactly one IDLE cycle (txd high).
- txd is registered (no glitches). busy = (state!=IDLE) | (fifo_count!=0).
- Baud counter counts 0..BAUD_DIV-1 and wraps; a bit advances on wrap.
- FIFO pointers are FIFO_AW bits and wrap modulo depth. Count is tracked separately so full and empty are unambiguous.

Test Plan:
- BAUD_DIV=4, single match nonce 32'h0000318f at cycle 10 -> txd low from cycle 12. Decoded bytes 8f,31,00,00. busy falls at cycle 12+160. overflow=0.
- Two matches 32'h11223344 and 32'hAABBCCDD on consecutive cycles -> bytes 44,33,22,11 then exactly 1 idle cycle, then DD,CC,BB,AA. fifo_count peaks at 1.
- FIFO_AW=2, six single-cycle matches while the first frame is shifting:
  - 1 word in flight plus 4 queued; the 6th is dropped and overflow=1.
  - Exactly 5 words are transmitted, in order.
- Match in the same cycle as an IDLE pop with FIFO full -> accepted. fifo_count stays 4. overflow stays 0.
- reset_n low mid DATA of byte 2 -> txd=1 within the same cycle. FIFO empty, overflow cleared. After release, a new match transmits a clean frame.
- BAUD_DIV=217, one nonce -> each bit exactly 217 cycles wide. Total frame 8680 cycles.
